// File: rtl/mul_instr_encoder_pkg.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module : mul_instr_encoder_pkg
// Brief  : Field positions, opcode constants and encode helpers for the
//          multiply / data-processing instruction encoder.
// Rev    : 1.0
//============================================================================
package mul_instr_encoder_pkg;

   localparam int COND_LSB     = 28;
   localparam int S_BIT_POS    = 20;

   localparam int MUL_A_POS    = 21;
   localparam int MUL_RD_LSB   = 16;
   localparam int MUL_RA_LSB   = 12;
   localparam int MUL_RM_LSB   = 8;
   localparam int MUL_MARK_LSB = 4;
   localparam int MUL_RN_LSB   = 0;

   localparam int DP_CMD_LSB   = 21;
   localparam int DP_RN_LSB    = 16;
   localparam int DP_RD_LSB    = 12;
   localparam int DP_RM_LSB    = 0;

   localparam logic [3:0] MUL_MARKER = 4'b1001;
   localparam logic [3:0] PC_REG     = 4'd15;

   typedef enum logic [3:0] {
      CMD_AND = 4'b0000,
      CMD_SUB = 4'b0010,
      CMD_ADD = 4'b0100,
      CMD_ORR = 4'b1100
   } dp_cmd_e;

   function automatic logic [31:0] encode_mul(
      input logic [3:0] cond,
      input logic       s_bit,
      input logic       acc,
      input logic [3:0] rd,
      input logic [3:0] ra_field,
      input logic [3:0] rm,
      input logic [3:0] rn
   );
      logic [31:0] w;
      w = '0;
      w[COND_LSB +: 4]     = cond;
      w[MUL_A_POS]         = acc;
      w[S_BIT_POS]         = s_bit;
      w[MUL_RD_LSB +: 4]   = rd;
      w[MUL_RA_LSB +: 4]   = ra_field;
      w[MUL_RM_LSB +: 4]   = rm;
      w[MUL_MARK_LSB +: 4] = MUL_MARKER;
      w[MUL_RN_LSB +: 4]   = rn;
      return w;
   endfunction

   function automatic logic [31:0] encode_dp(
      input logic [3:0] cond,
      input logic [3:0] cmd,
      input logic       s_bit,
      input logic [3:0] rn,
      input logic [3:0] rd,
      input logic [3:0] rm
   );
      logic [31:0] w;
      w = '0;
      w[COND_LSB +: 4]   = cond;
      w[DP_CMD_LSB +: 4] = cmd;
      w[S_BIT_POS]       = s_bit;
      w[DP_RN_LSB +: 4]  = rn;
      w[DP_RD_LSB +: 4]  = rd;
      w[DP_RM_LSB +: 4]  = rm;
      return w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_instr_encoder_fifo.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module : instr_fifo
// Brief  : Synchronous DEPTH x WIDTH buffer for encoded words; clr flushes.
// Rev    : 1.0
//============================================================================
module instr_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full && !clr;
   assign do_pop  = pop && !empty && !clr;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule
`default_nettype wire

// File: rtl/mul_instr_encoder.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module : mul_instr_encoder
// Brief  : Encodes multiply / data-processing requests and streams them into
//          instruction memory. Macro MUL_ACCUM_EN enables multiply-accumulate.
// Rev    : 1.0
//============================================================================
module mul_instr_encoder
   import mul_instr_encoder_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        op_mul,
   input  logic        op_acc,
   input  logic [3:0]  cond,
   input  logic [3:0]  cmd,
   input  logic        s_bit,
   input  logic [3:0]  rn,
   input  logic [3:0]  rm,
   input  logic [3:0]  ra,
   input  logic [3:0]  rd,
   output logic        mem_we,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [15:0] words_written,
   output logic        err
);

   logic        ready_en;
   logic        full;
   logic        empty;
   logic        accept;
   logic        illegal;
   logic        push;
   logic        pop;
   logic        use_acc;
   logic [3:0]  ra_field;
   logic [31:0] word;
   logic [31:0] head;

`ifdef MUL_ACCUM_EN
   assign use_acc  = op_acc;
   assign ra_field = op_acc ? ra : 4'd0;
`else
   logic unused_acc_inputs;
   assign unused_acc_inputs = ^{op_acc, ra};
   assign use_acc  = 1'b0;
   assign ra_field = 4'd0;
`endif

   // ready_en keeps in_ready low until the first edge after reset release.
   assign in_ready = ready_en && !full;
   assign accept   = in_valid && in_ready;
   assign illegal  = op_mul && ((rd == PC_REG) || (rn == PC_REG) || (rm == PC_REG) ||
                                (use_acc && (ra == PC_REG)));
   assign push     = accept && !illegal;
   assign pop      = !empty && mem_ready;

   assign word = op_mul ? encode_mul(cond, s_bit, use_acc, rd, ra_field, rm, rn)
                        : encode_dp(cond, cmd, s_bit, rn, rd, rm);

   assign mem_we    = !empty;
   assign mem_wdata = empty ? 32'd0 : head;

   instr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .push  (push),
      .pop   (pop),
      .wdata (word),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_en      <= 1'b0;
         mem_addr      <= BASE_ADDR;
         words_written <= '0;
         err           <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (clr) begin
            mem_addr      <= BASE_ADDR;
            words_written <= '0;
            err           <= 1'b0;
         end else begin
            if (pop) begin
               mem_addr      <= mem_addr + 32'd4;
               words_written <= words_written + 16'd1;
            end
            if (accept && illegal) err <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mul_instr_encoder.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module : tb_mul_instr_encoder
// Brief  : Directed self-checking bench for mul_instr_encoder (depth 4, base 0).
// Rev    : 1.0
//============================================================================
module tb_mul_instr_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr;
   logic        in_valid;
   logic        in_ready;
   logic        op_mul;
   logic        op_acc;
   logic [3:0]  cond;
   logic [3:0]  cmd;
   logic        s_bit;
   logic [3:0]  rn;
   logic [3:0]  rm;
   logic [3:0]  ra;
   logic [3:0]  rd;
   logic        mem_we;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [15:0] words_written;
   logic        err;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   mul_instr_encoder #(
      .FIFO_DEPTH (4),
      .BASE_ADDR  (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .clr           (clr),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .op_mul        (op_mul),
      .op_acc        (op_acc),
      .cond          (cond),
      .cmd           (cmd),
      .s_bit         (s_bit),
      .rn            (rn),
      .rm            (rm),
      .ra            (ra),
      .rd            (rd),
      .mem_we        (mem_we),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .words_written (words_written),
      .err           (err)
   );

   // Present a request and hold it until accepted; returns at edge+1.
   task automatic send(input logic m, input logic a, input logic [3:0] c, input logic [3:0] k,
                       input logic s, input logic [3:0] n, input logic [3:0] mm,
                       input logic [3:0] aa, input logic [3:0] d);
      int waited;
      @(posedge clk); #1;
      op_mul = m; op_acc = a; cond = c; cmd = k; s_bit = s;
      rn = n; rm = mm; ra = aa; rd = d; in_valid = 1'b1;
      waited = 0;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (waited >= 50) $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      else passed++;
      checks++;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_ready();
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
   endtask

   task automatic do_clr();
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; clr = 1'b0; in_valid = 1'b0; mem_ready = 1'b0;
      op_mul = 0; op_acc = 0; cond = 0; cmd = 0; s_bit = 0; rn = 0; rm = 0; ra = 0; rd = 0;
      repeat (3) @(posedge clk);
      #1;
      if ({in_ready, mem_we, err} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {in_ready, mem_we, err});
      else passed++;
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || words_written !== 16'h0)
         $display("FAIL rst_values: addr=%h wdata=%h ww=%0d want 0/0/0", mem_addr, mem_wdata, words_written);
      else passed++;
      checks++;
      @(negedge clk); reset = 1'b1;
      #1;
      if (in_ready !== 1'b0) $display("FAIL rst_ready_before_edge: got %b want 0", in_ready);
      else passed++;
      checks++;
      @(posedge clk); #1;
      if (in_ready !== 1'b1) $display("FAIL rst_ready_after_edge: got %b want 1", in_ready);
      else passed++;
      checks++;
   endtask

   task automatic test_mul();
      mem_ready = 1'b0;
      send(1, 0, 4'hE, 4'h0, 0, 4'd3, 4'd4, 4'd9, 4'd2);
      if (mem_we !== 1'b1 || mem_wdata !== 32'hE0020493)
         $display("FAIL mul_word: we=%b wdata=%h want 1/e0020493", mem_we, mem_wdata);
      else passed++;
      checks++;
      if (mem_addr !== 32'h0) $display("FAIL mul_addr: got %h want 00000000", mem_addr);
      else passed++;
      checks++;
      pulse_ready();
      if (mem_we !== 1'b0 || mem_addr !== 32'h4 || words_written !== 16'd1)
         $display("FAIL mul_write_done: we=%b addr=%h ww=%0d want 0/4/1", mem_we, mem_addr, words_written);
      else passed++;
      checks++;
   endtask

   task automatic test_acc();
      logic [31:0] exp_word;
`ifdef MUL_ACCUM_EN
      exp_word = 32'hE0256798;
`else
      exp_word = 32'hE0050798;
`endif
      send(1, 1, 4'hE, 4'h0, 0, 4'd8, 4'd7, 4'd6, 4'd5);
      if (mem_wdata !== exp_word) $display("FAIL acc_word: got %h want %h", mem_wdata, exp_word);
      else passed++;
      checks++;
      pulse_ready();
   endtask

   task automatic test_dp();
      send(0, 0, 4'hE, 4'b0100, 0, 4'd1, 4'd3, 4'd0, 4'd2);
      if (mem_wdata !== 32'hE0812003) $display("FAIL dp_add: got %h want e0812003", mem_wdata);
      else passed++;
      checks++;
      pulse_ready();
      send(0, 0, 4'h0, 4'b0010, 1, 4'hA, 4'hC, 4'hF, 4'hB);
      if (mem_wdata !== 32'h005AB00C || err !== 1'b0)
         $display("FAIL dp_sub: wdata=%h err=%b want 005ab00c/0", mem_wdata, err);
      else passed++;
      checks++;
      pulse_ready();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_words [5];
      int k;
      int cyc;
      logic take;
      for (int i = 0; i < 4; i++) exp_words[i] = 32'hE1800000 | i;
      exp_words[4] = 32'hE1800005;
      do_clr();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(0, 0, 4'hE, 4'b1100, 0, 4'd0, i[3:0], 4'd0, 4'd0);
      if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready);
      else passed++;
      checks++;
      op_mul = 0; cond = 4'hE; cmd = 4'b1100; s_bit = 0; rn = 0; rd = 0; rm = 4'd5;
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || mem_wdata !== exp_words[0])
         $display("FAIL full_hold: ready=%b wdata=%h want 0/%h", in_ready, mem_wdata, exp_words[0]);
      else passed++;
      checks++;
      mem_ready = 1'b1;
      k = 0; cyc = 0;
      while (k < 5 && cyc < 20) begin
         take = in_valid && in_ready;
         if (mem_we) begin
            if (mem_addr !== 32'(k * 4)) $display("FAIL drain_addr%0d: got %h want %h", k, mem_addr, 32'(k * 4));
            else passed++;
            checks++;
            if (mem_wdata !== exp_words[k]) $display("FAIL drain_word%0d: got %h want %h", k, mem_wdata, exp_words[k]);
            else passed++;
            checks++;
            k++;
         end
         @(posedge clk); #1;
         if (take) in_valid = 1'b0;
         cyc++;
      end
      mem_ready = 1'b0;
      if (k != 5) $display("FAIL drain_timeout: writes=%0d want 5", k);
      else passed++;
      checks++;
      if (words_written !== 16'd5 || mem_we !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL drain_end: ww=%0d we=%b ready=%b want 5/0/1", words_written, mem_we, in_ready);
      else passed++;
      checks++;
   endtask

   task automatic test_illegal_clr();
      do_clr();
      send(0, 0, 4'hE, 4'b0000, 0, 4'd1, 4'd2, 4'd0, 4'd3);
      pulse_ready();
      send(1, 0, 4'hE, 4'h0, 0, 4'd1, 4'd2, 4'd0, 4'd15);
      if (mem_we !== 1'b0 || err !== 1'b1 || in_ready !== 1'b1)
         $display("FAIL illegal_rd15: we=%b err=%b ready=%b want 0/1/1", mem_we, err, in_ready);
      else passed++;
      checks++;
      send(1, 0, 4'hE, 4'h0, 0, 4'd15, 4'd2, 4'd0, 4'd1);
      send(0, 0, 4'hE, 4'b0100, 0, 4'd1, 4'd3, 4'd0, 4'd2);
      send(0, 0, 4'hE, 4'b0100, 0, 4'd1, 4'd3, 4'd0, 4'd2);
      if (mem_we !== 1'b1 || err !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'hE0812003)
         $display("FAIL illegal_sticky: we=%b err=%b addr=%h wdata=%h want 1/1/4/e0812003",
                  mem_we, err, mem_addr, mem_wdata);
      else passed++;
      checks++;
      do_clr();
      if (mem_we !== 1'b0 || mem_addr !== 32'h0 || err !== 1'b0 || words_written !== 16'd0)
         $display("FAIL clr_flush: we=%b addr=%h err=%b ww=%0d want 0/0/0/0", mem_we, mem_addr, err, words_written);
      else passed++;
      checks++;
   endtask

   task automatic test_reset_midstream();
      send(0, 0, 4'hE, 4'b0000, 0, 4'd1, 4'd2, 4'd0, 4'd3);
      pulse_ready();
      send(1, 0, 4'hE, 4'h0, 0, 4'd15, 4'd2, 4'd0, 4'd1);
      send(0, 0, 4'hE, 4'b0100, 0, 4'd1, 4'd3, 4'd0, 4'd2);
      send(0, 0, 4'hE, 4'b0100, 0, 4'd1, 4'd3, 4'd0, 4'd2);
      if (mem_we !== 1'b1 || err !== 1'b1 || words_written !== 16'd1)
         $display("FAIL pre_reset: we=%b err=%b ww=%0d want 1/1/1", mem_we, err, words_written);
      else passed++;
      checks++;
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      if ({in_ready, mem_we, err} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || words_written !== 16'd0)
         $display("FAIL async_reset: rdy/we/err=%b addr=%h wdata=%h ww=%0d want 000/0/0/0",
                  {in_ready, mem_we, err}, mem_addr, mem_wdata, words_written);
      else passed++;
      checks++;
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      if (in_ready !== 1'b1 || mem_we !== 1'b0)
         $display("FAIL reset_release: ready=%b we=%b want 1/0", in_ready, mem_we);
      else passed++;
      checks++;
   endtask

   initial begin
      test_reset();
      test_mul();
      test_acc();
      test_dp();
      test_back_to_back();
      test_illegal_clr();
      test_reset_midstream();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mul_instr_encoder.md
MUL_INSTR_ENCODER -- requirements
Module: mul_instr_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of encoded-word buffer entries (power of two, at least 2).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first instruction-memory byte address written.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port clr, input, 1 bit, synchronous flush of the buffer and reload of the address to BASE_ADDR.
REQ-006 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the request handshake.
REQ-007 The block SHALL have port op_mul, input, 1 bit: 1 selects multiply format, 0 selects data-processing register format.
REQ-008 The block SHALL have port op_acc, input, 1 bit: multiply-accumulate request.
REQ-009 The block SHALL have ports cond (input, 4, condition field), cmd (input, 4, data-processing opcode) and s_bit (input, 1, set-flags bit).
REQ-010 The block SHALL have ports rn, rm, ra and rd, each input, 4 bits, register numbers.
REQ-011 The block SHALL have ports mem_we (output, 1), mem_ready (input, 1), mem_addr (output, 32) and mem_wdata (output, 32), the instruction-memory write port.
REQ-012 The block SHALL have ports words_written (output, 16, completed writes, wrapping) and err (output, 1, sticky illegal-request flag).

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-014 in_ready SHALL be 1 exactly when the buffer is not full; no same-cycle pass-through is allowed when full.
REQ-015 Multiply format SHALL be: [31:28]=cond, [27:22]=0, [21]=A, [20]=s_bit, [19:16]=rd, [15:12]=Ra field, [11:8]=rm, [7:4]=4'b1001, [3:0]=rn.
REQ-016 Data-processing format SHALL be: [31:28]=cond, [27:25]=0, [24:21]=cmd, [20]=s_bit, [19:16]=rn, [15:12]=rd, [11:4]=0, [3:0]=rm.
REQ-017 For op_mul=1 with no accumulate, A SHALL be 0 and the Ra field SHALL be 4'b0000 whatever ra holds.
REQ-018 An accepted op_mul=1 request with any of rd, rn or rm equal to 15 SHALL NOT be enqueued; it SHALL set err; in_ready is unaffected.
REQ-019 An accepted word SHALL be pushed on the same edge and SHALL appear on mem_wdata no earlier than the following cycle.
REQ-020 mem_we SHALL be 1 exactly when the buffer is not empty; mem_wdata SHALL be the oldest entry; mem_addr SHALL be the current address.
REQ-021 A write SHALL complete on an edge where mem_we and mem_ready are both 1; that edge pops the entry, adds 4 to mem_addr (wrapping modulo 2^32) and increments words_written (wrapping).
REQ-022 A simultaneous push and pop SHALL leave the occupancy unchanged; entries are preserved in FIFO order.
REQ-023 clr SHALL take priority over push and pop in the same cycle: the buffer empties, mem_addr returns to BASE_ADDR, words_written returns to 0, and err is cleared.

Reset
REQ-024 While reset is 0, the block SHALL hold: buffer empty, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, words_written=0, err=0.
REQ-025 in_ready SHALL rise on the first clock edge after reset deasserts; a reset in mid-stream discards all buffered words.

Configuration
REQ-026 With macro MUL_ACCUM_EN defined, op_mul=1 and op_acc=1 SHALL encode A=1 and the Ra field = ra, and ra=15 SHALL also raise err.
REQ-027 Without MUL_ACCUM_EN, op_acc SHALL be ignored: A=0 and Ra field=0 for every multiply.

Structure
REQ-028 A shared package SHALL hold the field bit positions, the 4'b1001 multiply marker, the cmd constants (ADD=4'b0100, SUB=4'b0010, AND=4'b0000, ORR=4'b1100) and the PC register number 15.
REQ-029 The buffer SHALL be a sub-module named instr_fifo (synchronous, FIFO_DEPTH x 32, full/empty outputs).

Verification
REQ-030 Request cond=E, op_mul=1, rd=2, rn=3, rm=4, ra=9 -> mem_wdata=32'hE0020493 at mem_addr=BASE_ADDR.
REQ-031 With MUL_ACCUM_EN defined: op_acc=1, rd=5, ra=6, rm=7, rn=8 -> 32'hE0256798; without it, the same request -> 32'hE0050798.
REQ-032 Data-processing request cond=E, cmd=ADD, s_bit=0, rn=1, rd=2, rm=3 -> 32'hE0812003.
REQ-033 Hold mem_ready=0 and send 5 requests with depth 4 -> in_ready=0 after the 4th request; then release mem_ready -> 4 writes at addresses 0x0, 0x4, 0x8, 0xC in order, the 5th is accepted afterwards, and words_written=5.
REQ-034 A multiply with rd=15 -> no write occurs and err=1 until clr; assert clr while 2 words are buffered -> mem_we=0 the next cycle and mem_addr=BASE_ADDR.
REQ-035 Pull reset to 0 while mem_we=1 -> all outputs immediately take their reset values, and in_ready=1 one edge after release.
